register_file_2r1w: RTL

Parametrised successor to the processor's single-port register file: one write port, two independent registered read ports, and a hardware clear sequencer that zeroes the array one entry per cycle. It sits in the datapath between the decode stage, which issues two operand reads per instruction, and the writeback stage, which issues one write.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_rd_port.sv | 61 ++++++
 rtl/register_file_2r1w.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for register_file_2r1w: clear-FSM state encoding and default sizes.
// REGFILE_BYPASS_EN (optional) switches the read ports from read-first to write-first.
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

  localparam int RF_DATA_W = 20;
  localparam int RF_ADDR_W = 4;
  localparam int RF_DEPTH  = 10;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: range check, optional forwarding, output and valid registers.
// With REGFILE_BYPASS_EN defined, same-cycle writes and clears are forwarded to the read.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DEPTH  = RF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] mem [DEPTH],
`ifdef REGFILE_BYPASS_EN
  input  logic              wr_fire,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clearing,
  input  logic [ADDR_W-1:0] clr_idx,
`endif
  output logic [DATA_W-1:0] out_data,
  output logic              valid
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  logic              in_range;
  logic [DATA_W-1:0] rd_data;

  assign in_range = ({1'b0, addr} < DEPTH_W);

  always_comb begin
    rd_data = '0;
    if (in_range) begin
      rd_data = mem[addr];
    end
`ifdef REGFILE_BYPASS_EN
    // wr_fire is already range-qualified and never coincides with a clear cycle
    if (wr_fire && (wr_addr == addr)) begin
      rd_data = in_data;
    end
    if (clearing && (clr_idx == addr)) begin
      rd_data = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= rd;
      if (rd) begin
        out_data <= rd_data;
      end
    end
  end

endmodule

// File: rtl/register_file_2r1w.sv
// Two-read/one-write register file with a clear sweep zeroing one entry per cycle.
// Optional macro REGFILE_BYPASS_EN makes both read ports write-first on collisions.
module register_file_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DEPTH  = RF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              wr_ready,
  input  logic              rd_a,
  input  logic              rd_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              valid_a,
  output logic              valid_b,
  input  logic              clr,
  output logic              busy,
  output logic              clr_done
);

  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  rf_state_t         state_reg, state_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic              clr_done_reg, clr_done_next;
  logic              clearing;
  logic              wr_fire;
  logic [DATA_W-1:0] mem [DEPTH];

  assign clearing = (state_reg == RF_CLEAR);
  assign busy     = clearing;
  assign clr_done = clr_done_reg;
  assign wr_ready = (state_reg == RF_IDLE) && !clr;
  // Out-of-range writes handshake normally but never reach the array
  assign wr_fire  = wr && wr_ready && ({1'b0, wr_addr} < DEPTH_W);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [DATA_W-1:0] entry_reg;
    logic              wr_sel;
    logic              clr_sel;

    assign wr_sel  = wr_fire && (wr_addr == ADDR_W'(gi));
    assign clr_sel = clearing && (idx_reg == ADDR_W'(gi));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        entry_reg <= '0;
      end else if (clr_sel) begin
        entry_reg <= '0;
      end else if (wr_sel) begin
        entry_reg <= in_data;
      end
    end

    assign mem[gi] = entry_reg;
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    clr_done_next = 1'b0;
    case (state_reg)
      RF_IDLE: begin
        idx_next = '0;
        if (clr) begin
          state_next = RF_CLEAR;
        end
      end
      RF_CLEAR: begin
        if (idx_reg == LAST_IDX) begin
          state_next    = RF_IDLE;
          idx_next      = '0;
          clr_done_next = 1'b1;
        end else begin
          idx_next = idx_reg + ADDR_W'(1);
        end
      end
      default: begin
        state_next = RF_IDLE;
        idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= RF_IDLE;
      idx_reg      <= '0;
      clr_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      clr_done_reg <= clr_done_next;
    end
  end

  regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_port_a (
    .clk      (clk),
    .reset    (reset),
    .rd       (rd_a),
    .addr     (addr_a),
    .mem      (mem),
`ifdef REGFILE_BYPASS_EN
    .wr_fire  (wr_fire),
    .wr_addr  (wr_addr),
    .in_data  (in_data),
    .clearing (clearing),
    .clr_idx  (idx_reg),
`endif
    .out_data (out_a),
    .valid    (valid_a)
  );

  regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_port_b (
    .clk      (clk),
    .reset    (reset),
    .rd       (rd_b),
    .addr     (addr_b),
    .mem      (mem),
`ifdef REGFILE_BYPASS_EN
    .wr_fire  (wr_fire),
    .wr_addr  (wr_addr),
    .in_data  (in_data),
    .clearing (clearing),
    .clr_idx  (idx_reg),
`endif
    .out_data (out_b),
    .valid    (valid_b)
  );

endmodule
